// File: rtl/sound_pkg.sv
// Shared constants for the sound sequencer: command codes, note half-periods,
// melody tables and the sequencer state encoding.
package sound_pkg;

    localparam logic [3:0] SND_START  = 4'b1010;
    localparam logic [3:0] SND_GOAL   = 4'b1111;
    localparam logic [3:0] SND_SILENT = 4'b0000;
    localparam logic [3:0] SND_HOLD   = 4'b1000;

    // Square-wave half-periods in samples at 48 kHz.
    localparam logic [7:0] HALF_C5 = 8'd46;
    localparam logic [7:0] HALF_E5 = 8'd36;
    localparam logic [7:0] HALF_G5 = 8'd31;
    localparam logic [7:0] HALF_C6 = 8'd23;

    // Element [0] is the first note; the unused fourth goal slot is never played.
    localparam logic [3:0][7:0] START_NOTES = {HALF_C6, HALF_G5, HALF_E5, HALF_C5};
    localparam logic [3:0][7:0] GOAL_NOTES  = {HALF_C6, HALF_C6, HALF_G5, HALF_C6};
    localparam logic [1:0]      START_LAST  = 2'd3;
    localparam logic [1:0]      GOAL_LAST   = 2'd2;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
    typedef enum logic {MEL_START, MEL_GOAL} melody_e;

    function automatic logic [7:0] note_half(input melody_e mel, input logic [1:0] idx);
        return (mel == MEL_GOAL) ? GOAL_NOTES[idx] : START_NOTES[idx];
    endfunction

    function automatic logic [1:0] last_note(input melody_e mel);
        return (mel == MEL_GOAL) ? GOAL_LAST : START_LAST;
    endfunction

    function automatic logic is_melody(input logic [3:0] code);
        logic result;
        case (code)
            SND_START, SND_GOAL:  result = 1'b1;
            SND_SILENT, SND_HOLD: result = 1'b0;
            default:              result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave phase tracker: level is the polarity of the next sample to emit.
// restart rewinds to phase 0 / positive; step advances by one sample.
module tone_gen (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       step,
    input  logic       restart,
    input  logic [7:0] half,
    output logic       level
);

    logic [7:0] phase_reg, phase_next, base_phase;
    logic       level_reg, level_next, base_level;

    // restart and step together means "sample 0 was just emitted".
    always_comb begin
        base_phase = restart ? 8'd0 : phase_reg;
        base_level = restart ? 1'b1 : level_reg;
        phase_next = base_phase;
        level_next = base_level;
        if (step) begin
            if (base_phase >= half - 8'd1) begin
                phase_next = 8'd0;
                level_next = ~base_level;
            end else begin
                phase_next = base_phase + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            phase_reg <= 8'd0;
            level_reg <= 1'b1;
        end else begin
            phase_reg <= phase_next;
            level_reg <= level_next;
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/sound_player.sv
// Tone sequencer: captures sound-select changes and plays the matching melody
// as square-wave PCM, one registered sample per codec request.
module sound_player
    import sound_pkg::*;
#(
    parameter int                 NOTE_LEN = 4800,
    parameter int                 GAP_LEN  = 480,
    parameter logic signed [15:0] AMP      = 16'sd8192
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic [3:0]         SOUND_SELECT,
    input  logic               sample_req,
    output logic signed [15:0] sample,
    output logic               sample_valid,
    output logic               busy
);

    localparam logic [15:0] NOTE_LAST = 16'(NOTE_LEN - 1);
    localparam logic [15:0] GAP_LAST  = (GAP_LEN == 0) ? 16'd0 : 16'(GAP_LEN - 1);

    logic [3:0]         sel_prev_reg, pend_code_reg;
    logic               pending_reg;
    state_e             state_reg, state_next;
    melody_e            mel_reg, mel_next;
    logic [1:0]         idx_reg, idx_next;
    logic [15:0]        dur_reg, dur_next, gap_reg, gap_next;
    logic signed [15:0] sample_reg, sample_next;
    logic               valid_reg, valid_next;

    logic               tone_restart, tone_step, tone_level;
    logic [7:0]         tone_half;
    logic               play_now, note_done, cur_level;
    logic [15:0]        cur_dur;

    // A fresh change must win over the clear from a coincident request.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            sel_prev_reg  <= 4'b0000;
            pend_code_reg <= 4'b0000;
            pending_reg   <= 1'b0;
        end else if (SOUND_SELECT != sel_prev_reg) begin
            sel_prev_reg  <= SOUND_SELECT;
            pend_code_reg <= SOUND_SELECT;
            pending_reg   <= 1'b1;
        end else if (sample_req) begin
            pending_reg   <= 1'b0;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mel_next     = mel_reg;
        idx_next     = idx_reg;
        dur_next     = dur_reg;
        gap_next     = gap_reg;
        sample_next  = sample_reg;
        valid_next   = 1'b0;
        tone_restart = 1'b0;
        tone_step    = 1'b0;
        play_now     = 1'b0;
        note_done    = 1'b0;
        cur_dur      = dur_reg;
        cur_level    = tone_level;

        if (sample_req) begin
            valid_next = 1'b1;
            if (pending_reg) begin
                if (is_melody(pend_code_reg)) begin
                    // The loading request itself emits sample 0 of note 0.
                    mel_next     = (pend_code_reg == SND_GOAL) ? MEL_GOAL : MEL_START;
                    idx_next     = 2'd0;
                    play_now     = 1'b1;
                    cur_dur      = 16'd0;
                    cur_level    = 1'b1;
                    tone_restart = 1'b1;
                    tone_step    = 1'b1;
                end else begin
                    state_next  = IDLE;
                    sample_next = '0;
                end
            end else begin
                unique case (state_reg)
                    PLAY: begin
                        play_now  = 1'b1;
                        tone_step = 1'b1;
                    end
                    GAP: begin
                        sample_next = '0;
                        if (gap_reg == GAP_LAST) begin
                            note_done = 1'b1;
                        end else begin
                            gap_next = gap_reg + 16'd1;
                        end
                    end
                    default: sample_next = '0;
                endcase
            end

            if (play_now) begin
                sample_next = cur_level ? AMP : -AMP;
                if (cur_dur == NOTE_LAST) begin
                    if (GAP_LEN == 0) begin
                        note_done = 1'b1;
                    end else begin
                        state_next = GAP;
                        gap_next   = 16'd0;
                    end
                end else begin
                    state_next = PLAY;
                    dur_next   = cur_dur + 16'd1;
                end
            end

            if (note_done) begin
                if (idx_next == last_note(mel_next)) begin
                    state_next = IDLE;
                end else begin
                    idx_next     = idx_next + 2'd1;
                    dur_next     = 16'd0;
                    state_next   = PLAY;
                    tone_restart = 1'b1;
                    tone_step    = 1'b0;
                end
            end
        end
    end

    assign tone_half = note_half(mel_next, idx_next);

    tone_gen u_tone (
        .Clk     (Clk),
        .Clr     (Clr),
        .step    (tone_step),
        .restart (tone_restart),
        .half    (tone_half),
        .level   (tone_level)
    );

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_reg  <= IDLE;
            mel_reg    <= MEL_START;
            idx_reg    <= 2'd0;
            dur_reg    <= 16'd0;
            gap_reg    <= 16'd0;
            sample_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mel_reg    <= mel_next;
            idx_reg    <= idx_next;
            dur_reg    <= dur_next;
            gap_reg    <= gap_next;
            sample_reg <= sample_next;
            valid_reg  <= valid_next;
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player: melody tables checked against hand-computed
// sample/busy vectors, plus hand sequences for abort, replay and reset.
module tb_sound_player;

    localparam int                 NOTE_LEN = 100;
    localparam int                 GAP_LEN  = 4;
    localparam logic signed [15:0] AMP      = 16'sd8192;
    localparam int                 CAP      = 420;

    logic               clk = 1'b0;
    logic               clr_n = 1'b0;
    logic               sample_req = 1'b0;
    logic [3:0]         sound_select = 4'b0000;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;

    sound_player #(.NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN), .AMP(AMP)) dut (
        .Clk          (clk),
        .Clr          (clr_n),
        .SOUND_SELECT (sound_select),
        .sample_req   (sample_req),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit goal;
        int idx;
        int exp_sample;
        bit exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   valid_bad = 0;
    int   start_s[CAP];
    bit   start_b[CAP];
    int   goal_s[CAP];
    bit   goal_b[CAP];
    int   seq_s[64];
    bit   seq_b[64];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One request every 4 clocks; outputs read on the falling edge after it.
    task automatic do_req(output int s, output bit b);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        s = sample;
        b = busy;
        if (sample_valid !== 1'b1) valid_bad++;
        @(negedge clk);
        if (sample_valid !== 1'b0) valid_bad++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_code(input logic [3:0] code);
        sound_select = code;
        @(negedge clk);
    endtask

    // Expected sample n of a melody, straight from the note/gap/half-period rules.
    function automatic int model(input bit goal, input int n);
        int note, off, h;
        note = n / (NOTE_LEN + GAP_LEN);
        off  = n % (NOTE_LEN + GAP_LEN);
        if (note >= (goal ? 3 : 4) || off >= NOTE_LEN) return 0;
        if (goal) h = (note == 1) ? 31 : 23;
        else case (note)
            0: h = 46;
            1: h = 36;
            2: h = 31;
            default: h = 23;
        endcase
        return ((off / h) % 2 == 0) ? 8192 : -8192;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, bad;
        bit b;

        vecs = '{
            '{0, 0, 8192, 1},   '{0, 45, 8192, 1},   '{0, 46, -8192, 1},  '{0, 91, -8192, 1},
            '{0, 92, 8192, 1},  '{0, 99, 8192, 1},   '{0, 100, 0, 1},     '{0, 103, 0, 1},
            '{0, 104, 8192, 1}, '{0, 139, 8192, 1},  '{0, 140, -8192, 1}, '{0, 208, 8192, 1},
            '{0, 239, -8192, 1},'{0, 312, 8192, 1},  '{0, 335, -8192, 1}, '{0, 411, 8192, 1},
            '{0, 414, 0, 1},    '{0, 415, 0, 0},     '{0, 416, 0, 0},     '{0, 419, 0, 0},
            '{1, 0, 8192, 1},   '{1, 22, 8192, 1},   '{1, 23, -8192, 1},  '{1, 45, -8192, 1},
            '{1, 46, 8192, 1},  '{1, 99, 8192, 1},   '{1, 100, 0, 1},     '{1, 104, 8192, 1},
            '{1, 135, -8192, 1},'{1, 208, 8192, 1},  '{1, 231, -8192, 1}, '{1, 307, 8192, 1},
            '{1, 310, 0, 1},    '{1, 311, 0, 0},     '{1, 312, 0, 0},     '{1, 319, 0, 0}
        };

        // Reset with START held through it.
        clr_n = 1'b0;
        sound_select = 4'b1010;
        repeat (3) @(negedge clk);
        check("reset sample", sample, 0);
        check("reset sample_valid", sample_valid, 0);
        check("reset busy", busy, 0);
        clr_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < CAP; i++) do_req(start_s[i], start_b[i]);

        // Silence first, then the goal beep held across its end.
        set_code(4'b0000);
        do_req(s, b);
        check("silence sample", s, 0);
        check("silence busy", b, 0);
        set_code(4'b1111);
        for (int i = 0; i < CAP; i++) do_req(goal_s[i], goal_b[i]);

        foreach (vecs[i]) begin
            if (vecs[i].goal) begin
                check($sformatf("goal[%0d] sample", vecs[i].idx), goal_s[vecs[i].idx], vecs[i].exp_sample);
                check($sformatf("goal[%0d] busy", vecs[i].idx), goal_b[vecs[i].idx], vecs[i].exp_busy);
            end else begin
                check($sformatf("start[%0d] sample", vecs[i].idx), start_s[vecs[i].idx], vecs[i].exp_sample);
                check($sformatf("start[%0d] busy", vecs[i].idx), start_b[vecs[i].idx], vecs[i].exp_busy);
            end
        end

        bad = 0;
        for (int i = 0; i < CAP; i++) if (start_s[i] != model(1'b0, i)) bad++;
        check("start full-melody miscount", bad, 0);
        bad = 0;
        for (int i = 0; i < CAP; i++) if (goal_s[i] != model(1'b1, i)) bad++;
        check("goal full-melody miscount", bad, 0);

        // Replay after passing through 0000 for one clock, then abort at sample 50.
        set_code(4'b0000);
        set_code(4'b1111);
        for (int i = 0; i <= 50; i++) do_req(seq_s[i], seq_b[i]);
        check("replay[0] sample", seq_s[0], 8192);
        check("replay[0] busy", seq_b[0], 1);
        check("replay[23] sample", seq_s[23], -8192);
        check("replay[50] sample", seq_s[50], 8192);
        set_code(4'b1000);
        do_req(s, b);
        check("abort sample", s, 0);
        check("abort busy", b, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(s, b);
            if (s != 0 || b != 1'b0) bad++;
        end
        check("abort no-resume miscount", bad, 0);

        // Change lands in the same cycle as a request.
        sound_select = 4'b1111;
        do_req(s, b);
        check("same-cycle sample", s, 0);
        check("same-cycle busy", b, 0);
        do_req(s, b);
        check("after same-cycle sample", s, 8192);
        check("after same-cycle busy", b, 1);

        // Reset at goal sample 30, taken while sample_valid is high.
        for (int i = 2; i < 30; i++) do_req(s, b);
        check("pre-reset sample 29", s, -8192);
        sample_req = 1'b1;
        @(negedge clk);
        sample_req = 1'b0;
        sound_select = 4'b1010;
        clr_n = 1'b0;
        #1;
        check("mid-reset sample", sample, 0);
        check("mid-reset sample_valid", sample_valid, 0);
        check("mid-reset busy", busy, 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50; i++) do_req(seq_s[i], seq_b[i]);
        check("restart[0] sample", seq_s[0], 8192);
        check("restart[0] busy", seq_b[0], 1);
        check("restart[23] sample", seq_s[23], 8192);
        check("restart[45] sample", seq_s[45], 8192);
        check("restart[46] sample", seq_s[46], -8192);

        check("sample_valid pulse errors", valid_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
